// File: rtl/regb_fifo_pkg.sv
// Shared helpers for the register-based FIFO: count width and parameter checks.
package regb_fifo_pkg;

    // Width needed to hold a fill level of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Legal parameter set: at least two entries, thresholds inside the fill range.
    function automatic bit params_ok(input int depth, input int af_thresh, input int ae_thresh);
        return (depth >= 2) && (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh < depth);
    endfunction

endpackage

// File: rtl/regb_fifo_ext_if.sv
// Producer/consumer bundle for regb_fifo_ext.
// Handshake: a word moves in on a clock edge where shift_in is high and the
// FIFO is not full (or is full but shift_out is also high); a word moves out
// on an edge where shift_out is high and the FIFO is not empty. out is the
// head word whenever empty is low (first-word fall-through), zero otherwise.
interface regb_fifo_ext_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5
);
    import regb_fifo_pkg::*;

    logic                      shift_in;
    logic [WIDTH-1:0]          in;
    logic                      shift_out;
    logic [WIDTH-1:0]          out;
    logic                      flush;
    logic                      clr_err;
    logic                      full;
    logic                      empty;
    logic                      almost_full;
    logic                      almost_empty;
    logic [cnt_w(DEPTH)-1:0]   count;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output shift_in, in, shift_out, flush, clr_err,
        input  out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  shift_in, in, shift_out, flush, clr_err,
        output out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/regb_fifo_ptr.sv
// Modulo-DEPTH pointer with increment enable and synchronous clear.
module regb_fifo_ptr #(
    parameter int DEPTH = 5,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          res,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [PW-1:0] o_ptr
);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] r_ptr;

    // Advance by one on i_inc, wrapping explicitly at DEPTH-1 (DEPTH need not be 2^n).
    always_ff @(posedge clk) begin
        if (res || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/regb_fifo_ext.sv
// Flop-based FIFO with fill level, programmable almost flags, flush,
// sticky overflow/underflow and read-during-full pass-through.
module regb_fifo_ext #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 5,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic             clk,
    input  logic             res,
    regb_fifo_ext_if.slave   bus
);
    import regb_fifo_pkg::*;

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("regb_fifo_ext: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic [PW-1:0]    w_wr_ptr;
    logic [PW-1:0]    w_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_ovf_ev;
    logic             w_unf_ev;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Flush masks every shift request; a full FIFO still accepts a write
    // when the head is leaving in the same cycle.
    assign w_wr_en  = !bus.flush && bus.shift_in && (!w_full || bus.shift_out);
    assign w_rd_en  = !bus.flush && bus.shift_out && !w_empty;
    assign w_ovf_ev = !bus.flush && bus.shift_in && w_full && !bus.shift_out;
    assign w_unf_ev = !bus.flush && bus.shift_out && w_empty;

    regb_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk   (clk),
        .res   (res),
        .i_clr (bus.flush),
        .i_inc (w_wr_en),
        .o_ptr (w_wr_ptr)
    );

    regb_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk   (clk),
        .res   (res),
        .i_clr (bus.flush),
        .i_inc (w_rd_en),
        .o_ptr (w_rd_ptr)
    );

    // Storage write; contents are never cleared since out is masked when empty.
    always_ff @(posedge clk) begin
        if (!res && w_wr_en) begin
            r_mem[w_wr_ptr] <= bus.in;
        end
    end

    // Fill level: simultaneous accepted read and write leave it unchanged.
    always_ff @(posedge clk) begin
        if (res || bus.flush) begin
            r_count <= '0;
        end else if (w_wr_en && !w_rd_en) begin
            r_count <= r_count + CW'(1);
        end else if (w_rd_en && !w_wr_en) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Sticky error flags; a new error event beats clr_err in the same cycle.
    always_ff @(posedge clk) begin
        if (res) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !bus.clr_err) || w_ovf_ev;
            r_underflow <= (r_underflow && !bus.clr_err) || w_unf_ev;
        end
    end

    assign bus.out          = w_empty ? '0 : r_mem[w_rd_ptr];
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= CW'(AF_THRESH));
    assign bus.almost_empty = (r_count <= CW'(AE_THRESH));
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_regb_fifo_ext.sv
// Self-checking bench for regb_fifo_ext: directed vector table plus a
// randomized phase, all checked against a queue-based reference model.
module tb_regb_fifo_ext;
  localparam int W  = 4;
  localparam int D  = 5;
  localparam int AF = D - 1;
  localparam int AE = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  regb_fifo_ext_if #(.WIDTH(W), .DEPTH(D)) bus ();

  regb_fifo_ext #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO: a queue plus two sticky bits, following the rules directly.
  task automatic model_step(input bit rs, input bit fl, input bit ce,
                            input bit si, input bit so, input logic [W-1:0] din);
    bit ov_ev, un_ev, do_rd, do_wr;
    if (rs) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      ov_ev = 1'b0;
      un_ev = 1'b0;
      if (fl) begin
        exp_q.delete();
      end else begin
        ov_ev = si && (exp_q.size() == D) && !so;
        un_ev = so && (exp_q.size() == 0);
        do_rd = so && (exp_q.size() > 0);
        do_wr = si && ((exp_q.size() < D) || so);
        if (do_rd) void'(exp_q.pop_front());
        if (do_wr) exp_q.push_back(din);
      end
      m_ovf = (m_ovf && !ce) || ov_ev;
      m_unf = (m_unf && !ce) || un_ev;
    end
  endtask

  task automatic compare_model();
    int n;
    n = exp_q.size();
    check("count",        int'(bus.count),        n);
    check("out",          int'(bus.out),          (n > 0) ? int'(exp_q[0]) : 0);
    check("full",         int'(bus.full),         int'(n == D));
    check("empty",        int'(bus.empty),        int'(n == 0));
    check("almost_full",  int'(bus.almost_full),  int'(n >= AF));
    check("almost_empty", int'(bus.almost_empty), int'(n <= AE));
    check("overflow",     int'(bus.overflow),     int'(m_ovf));
    check("underflow",    int'(bus.underflow),    int'(m_unf));
  endtask

  // ---------------- driver ----------------
  // Apply one cycle of inputs, let the edge happen, sample 1 ns later.
  task automatic step(input bit rs, input bit fl, input bit ce,
                      input bit si, input bit so, input logic [W-1:0] din);
    res           = rs;
    bus.flush     = fl;
    bus.clr_err   = ce;
    bus.shift_in  = si;
    bus.shift_out = so;
    bus.in        = din;
    @(posedge clk);
    #1;
    model_step(rs, fl, ce, si, so, din);
    compare_model();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit         rs, fl, ce, si, so;
    logic [W-1:0] din;
    int         e_count, e_out;
    bit         e_ovf, e_unf;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  function automatic vec_t mk(bit rs, bit fl, bit ce, bit si, bit so, int din,
                              int e_count, int e_out, bit e_ovf, bit e_unf);
    vec_t v;
    v.rs = rs; v.fl = fl; v.ce = ce; v.si = si; v.so = so;
    v.din = W'(din);
    v.e_count = e_count; v.e_out = e_out; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  initial begin
    int lvl;
    bit si, so, fl, ce, rs;
    res = 1'b1; bus.flush = 0; bus.clr_err = 0;
    bus.shift_in = 0; bus.shift_out = 0; bus.in = '0;

    //               rs fl ce si so din  cnt out ovf unf
    vecs[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0,  0, 0);  // reset state
    vecs[1]  = mk(0, 0, 0, 1, 0, 1,   1, 1,  0, 0);  // fill 1..5, head stays 1
    vecs[2]  = mk(0, 0, 0, 1, 0, 2,   2, 1,  0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 0, 3,   3, 1,  0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 0, 4,   4, 1,  0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 0, 5,   5, 1,  0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 1, 6,   5, 2,  0, 0);  // pass-through at full
    vecs[7]  = mk(0, 0, 0, 1, 0, 7,   5, 2,  1, 0);  // overflow, 7 dropped
    vecs[8]  = mk(0, 0, 1, 0, 0, 0,   5, 2,  0, 0);  // clr_err
    vecs[9]  = mk(0, 0, 0, 0, 1, 0,   4, 3,  0, 0);  // drain 2..6
    vecs[10] = mk(0, 0, 0, 0, 1, 0,   3, 4,  0, 0);
    vecs[11] = mk(0, 0, 0, 0, 1, 0,   2, 5,  0, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 0,   1, 6,  0, 0);
    vecs[13] = mk(0, 0, 0, 0, 1, 0,   0, 0,  0, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 0,   0, 0,  0, 1);  // underflow
    vecs[15] = mk(0, 0, 1, 0, 0, 0,   0, 0,  0, 0);  // clr_err clears it
    vecs[16] = mk(0, 0, 0, 1, 1, 9,   1, 9,  0, 1);  // empty + both: write only
    vecs[17] = mk(0, 0, 1, 1, 0, 10,  2, 9,  0, 0);
    vecs[18] = mk(0, 0, 0, 1, 0, 11,  3, 9,  0, 0);
    vecs[19] = mk(0, 1, 0, 1, 0, 12,  0, 0,  0, 0);  // flush beats shift_in
    vecs[20] = mk(0, 0, 1, 0, 1, 0,   0, 0,  0, 1);  // set wins over clr_err
    vecs[21] = mk(0, 0, 0, 1, 0, 1,   1, 1,  0, 1);
    vecs[22] = mk(0, 0, 0, 1, 0, 2,   2, 1,  0, 1);
    vecs[23] = mk(1, 0, 0, 1, 1, 3,   0, 0,  0, 0);  // reset discards requests

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rs, vecs[i].fl, vecs[i].ce, vecs[i].si, vecs[i].so, vecs[i].din);
      check($sformatf("vec%0d_count", i), int'(bus.count),     vecs[i].e_count);
      check($sformatf("vec%0d_out", i),   int'(bus.out),       vecs[i].e_out);
      check($sformatf("vec%0d_ovf", i),   int'(bus.overflow),  int'(vecs[i].e_ovf));
      check($sformatf("vec%0d_unf", i),   int'(bus.underflow), int'(vecs[i].e_unf));
    end

    // Wrap sequence: hold fill level at 2..3 so both pointers wrap several times.
    step(0, 0, 0, 1, 0, W'($urandom_range(0, 15)));
    step(0, 0, 0, 1, 0, W'($urandom_range(0, 15)));
    for (int c = 0; c < 20; c++) begin
      lvl = exp_q.size();
      if (lvl <= 2) begin
        si = 1'b1; so = 1'(c % 2);
      end else begin
        so = 1'b1; si = 1'(c % 2);
      end
      step(0, 0, 0, si, so, W'($urandom_range(0, 15)));
      check("wrap_level_in_range", int'(bus.count >= 2 && bus.count <= 3), 1);
    end

    // Randomized traffic: first half biased to fill, second half biased to drain.
    for (int c = 0; c < 600; c++) begin
      if (c < 300) begin
        si = ($urandom_range(0, 3) != 0);
        so = ($urandom_range(0, 3) == 0);
      end else begin
        si = ($urandom_range(0, 3) == 0);
        so = ($urandom_range(0, 3) != 0);
      end
      fl = ($urandom_range(0, 31) == 0);
      ce = fl ? 1'b0 : ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 99) == 0);
      step(rs, fl, ce, si, so, W'($urandom_range(0, 15)));
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
